counter_bus_io: RTL
===================

# counter_bus_io

Bus-side access logic for one counter channel of the 8254-compatible timer. Decodes control words and byte-wide data writes from the 8-bit CPU bus and assembles the 16-bit initial count. Hands the count and mode to the counter core and returns count/status bytes on reads, including the counter-latch and read-back commands. Sits between the bus decoder and each counter core (modes 0–5); one instance per channel.

## Interface
- COUNTER_ID, 0: channel number 0–2; matched against the control-word SC field and the data address.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active-high; when 0, wr/rd are ignored.
- addr  in  2  0–2 select a counter data port; 3 selects the control register.
- wr  in  1  single-cycle write strobe.
- rd  in  1  single-cycle read strobe.
- data_in  in  8  write data.
- current_count  in  16  live count from the counter core.
- out_pin  in  1  counter core OUT, used for the status byte.
- ce_loaded  in  1  core pulse: count transferred into the counting element.
- data_out  out  8  read data.
- count_value  out  16  assembled initial count.
- count_load  out  1  one-cycle strobe: count_value is new.
- mode  out  3  programmed mode 0–5.
- bcd  out  1  programmed BCD flag; passed through, not interpreted here.

## Operation
- Control word fields: SC[7:6], RW[5:4], M[3:1], BCD[0]. A write is accepted only when cs=1, wr=1 and addr=3.
- **Programming** (SC=COUNTER_ID, RW≠00):
  - Store RW, mode and bcd. M=110 maps to mode 2; M=111 maps to mode 3.
  - Reset the write and read byte pointers to LSB.
  - Discard any partial LSB, clear both latches, set null_count=1.
- **Counter latch** (SC=COUNTER_ID, RW=00): if the count latch is empty, capture current_count and mark it full. Otherwise ignore. Mode and RW are unchanged.
- **Read-back** (SC=11): acts only if bit(1+COUNTER_ID)=1.
  - Bit5=0: latch the count, with the same rule as counter latch.
  - Bit4=0: latch status = {out_pin, null_count, RW[1:0], mode[2:0], bcd}, only if the status latch is empty.
- **Data write** (addr=COUNTER_ID):
  - RW=01: count_value={8'h00,d}.
  - RW=10: count_value={d,8'h00}.
  - RW=11: the first byte is held as LSB; the second byte completes {d,LSB}. The write pointer toggles.
  - count_load pulses on completion. Writes are ignored while RW=00 (unprogrammed, the reset state).
- **null_count**: set by programming or by a completed count write; cleared by ce_loaded. If both happen in the same cycle, set wins.
- **Read priority** (addr=COUNTER_ID):
  1. Status latch full: return status and empty the status latch.
  2. Count latch full: return the byte selected by RW and the read pointer. The latch empties after the last byte (one byte for RW=01/10, MSB for RW=11).
  3. Otherwise: return the live current_count byte. The read pointer toggles for RW=11.
- **Count value 0**: passed through unchanged; the core treats it as 65536.
- **wr and rd in the same cycle**: the write is processed and the read is ignored.
- **Pointer independence**: the write and read pointers are independent of each other.

## Timing
- **Reset values**:
  - data_out=0, count_value=0, count_load=0, mode=0, bcd=0.
  - RW=00, null_count=1, both pointers LSB, both latches empty.
- **Latch capture**: current_count is captured at the posedge that samples the command.
- **Read data**: data_out is registered and valid the cycle after rd. It holds until the next accepted read.
- **count_load**: registered, high exactly one cycle, in the cycle after the completing write. count_value is stable from that cycle until the next load.
- **Reset mid-sequence**: rst at any point, including between LSB and MSB, returns to reset values immediately. No count_load is emitted.

## Structure
- **Shared package timer_pkg**:
  - RW codes (LATCH, LSB, MSB, LSB_MSB).
  - Control-word field positions.
  - CTRL_ADDR=3, READBACK_SC=2'b11.
  - Status-byte bit positions.
- **Sub-module count_latch**: owns the count/status latches, the read pointer and the data_out mux. The top level owns decode, the write path and null_count.

## Test plan
- **LSB/MSB load**: ctrl 8'h34 (ch0, RW=11, mode 2), then write 8'h10, 8'h27 → one count_load pulse with count_value=16'h2710, mode=2. null_count=1 until ce_loaded.
- **Counter latch**: live count 16'h1234, latch cmd 8'h00, core keeps counting, two reads → 8'h34, 8'h12. A third read returns the live LSB.
- **Repeat latch ignored**: latch at 16'h1234, second latch at 16'h1200 → the reads still return 8'h34, 8'h12.
- **Read-back**: read-back 8'hC2 with out_pin=1, RW=11, mode 2, binary, null_count=0 → first read 8'hB4, then the count LSB and MSB.
- **Reprogramming mid-sequence**: ctrl 8'h34, write 8'hAA, then ctrl 8'h14 (RW=01), then write 8'h05 → count_value=16'h0005. No load carries 8'hAA.
- **Ignored cycles and async reset**:
  - wr with cs=0 → no state change.
  - Simultaneous wr and rd → only the write takes effect.
  - rst pulse between LSB and MSB → all outputs return to reset values; a subsequent data write with RW=00 is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the bus-side access logic of the
// 8254-compatible timer channels.
// Contents: read/write access codes, control-word and read-back field
// positions, the control-register address, status-byte bit positions, and
// helpers for mode mapping and status-byte assembly.
package timer_pkg;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_e;

    // control word layout
    localparam int SC_HI   = 7;
    localparam int SC_LO   = 6;
    localparam int RW_HI   = 5;
    localparam int RW_LO   = 4;
    localparam int M_HI    = 3;
    localparam int M_LO    = 1;
    localparam int BCD_BIT = 0;

    // read-back command: active-low "latch count"/"latch status" bits and
    // the bit selecting counter 0 (counter n uses RB_SEL_LO + n)
    localparam int RB_NCOUNT_BIT  = 5;
    localparam int RB_NSTATUS_BIT = 4;
    localparam int RB_SEL_LO      = 1;

    localparam logic [1:0] CTRL_ADDR   = 2'd3;
    localparam logic [1:0] READBACK_SC = 2'b11;

    // status byte layout
    localparam int ST_OUT_BIT  = 7;
    localparam int ST_NULL_BIT = 6;
    localparam int ST_RW_HI    = 5;
    localparam int ST_RW_LO    = 4;
    localparam int ST_MODE_HI  = 3;
    localparam int ST_MODE_LO  = 1;
    localparam int ST_BCD_BIT  = 0;

    // M=110 and M=111 are aliases of modes 2 and 3
    function automatic logic [2:0] map_mode(input logic [2:0] m);
        return (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
    endfunction

    function automatic logic [7:0] make_status(input logic out_v, input logic null_v,
                                               input rw_e rw, input logic [2:0] mode_v,
                                               input logic bcd_v);
        logic [7:0] s;
        s                       = '0;
        s[ST_OUT_BIT]           = out_v;
        s[ST_NULL_BIT]          = null_v;
        s[ST_RW_HI:ST_RW_LO]    = rw;
        s[ST_MODE_HI:ST_MODE_LO] = mode_v;
        s[ST_BCD_BIT]           = bcd_v;
        return s;
    endfunction

endpackage

// File: rtl/counter_bus_io_if.sv
// counter_bus_io_if: 8-bit CPU bus as seen by one timer channel.
// Signals: cs (chip select), addr (0-2 data ports, 3 control), wr/rd
// (single-cycle strobes), data_in (write data), data_out (read data).
// master = bus driver (CPU/decoder side), slave = channel access logic.
interface counter_bus_io_if;
    logic       cs;
    logic [1:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output cs, addr, wr, rd, data_in, input data_out);
    modport slave  (input cs, addr, wr, rd, data_in, output data_out);
endinterface

// File: rtl/count_latch.sv
// count_latch: read side of one timer channel.
// Holds the count latch, the status latch and the read byte pointer, and
// registers the byte returned on each accepted read.
// Ports: clk/rst; clear (channel reprogrammed); latch_count/latch_status
// (capture requests); status_in (status byte to capture); current_count
// (live count); rw (programmed access mode); rd_en (accepted read of this
// channel); data_out (registered read data).
module count_latch
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        latch_count,
    input  logic        latch_status,
    input  logic [7:0]  status_in,
    input  logic [15:0] current_count,
    input  rw_e         rw,
    input  logic        rd_en,
    output logic [7:0]  data_out
);
    logic [15:0] cnt_q, cnt_d;
    logic        cnt_full_q, cnt_full_d;
    logic [7:0]  sts_q, sts_d;
    logic        sts_full_q, sts_full_d;
    logic        rd_msb_q, rd_msb_d;
    logic [7:0]  dout_q, dout_d;
    logic [15:0] rd_src;
    logic        rd_msb_sel;

    always_comb begin
        cnt_d      = cnt_q;
        cnt_full_d = cnt_full_q;
        sts_d      = sts_q;
        sts_full_d = sts_full_q;
        rd_msb_d   = rd_msb_q;
        dout_d     = dout_q;
        rd_src     = cnt_full_q ? cnt_q : current_count;
        rd_msb_sel = (rw == RW_MSB) || ((rw == RW_LSB_MSB) && rd_msb_q);

        if (clear) begin
            cnt_full_d = 1'b0;
            sts_full_d = 1'b0;
            rd_msb_d   = 1'b0;
        end else begin
            // a full latch keeps its first capture until it is read out
            if (latch_count && !cnt_full_q) begin
                cnt_d      = current_count;
                cnt_full_d = 1'b1;
            end
            if (latch_status && !sts_full_q) begin
                sts_d      = status_in;
                sts_full_d = 1'b1;
            end
            if (rd_en) begin
                if (sts_full_q) begin
                    dout_d     = sts_q;
                    sts_full_d = 1'b0;
                end else begin
                    dout_d = rd_msb_sel ? rd_src[15:8] : rd_src[7:0];
                    // in LSB/MSB mode the latch survives the LSB read
                    if (cnt_full_q && ((rw != RW_LSB_MSB) || rd_msb_q))
                        cnt_full_d = 1'b0;
                    if (rw == RW_LSB_MSB)
                        rd_msb_d = !rd_msb_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            cnt_full_q <= 1'b0;
            sts_q      <= '0;
            sts_full_q <= 1'b0;
            rd_msb_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cnt_full_q <= cnt_full_d;
            sts_q      <= sts_d;
            sts_full_q <= sts_full_d;
            rd_msb_q   <= rd_msb_d;
            dout_q     <= dout_d;
        end
    end

    assign data_out = dout_q;
endmodule

// File: rtl/counter_bus_io.sv
// counter_bus_io: bus-side access logic for one 8254-style counter channel.
// Decodes control words (program, counter latch, read-back), assembles the
// 16-bit initial count from byte writes, tracks null_count, and returns
// latched or live count/status bytes through count_latch.
// Ports: clk, rst (async, active-high); bus (slave side of the CPU bus);
// current_count/out_pin/ce_loaded from the counter core; count_value,
// count_load (one-cycle strobe), mode and bcd to the counter core.
module counter_bus_io
    import timer_pkg::*;
#(
    parameter int COUNTER_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    counter_bus_io_if.slave   bus,
    input  logic [15:0]       current_count,
    input  logic              out_pin,
    input  logic              ce_loaded,
    output logic [15:0]       count_value,
    output logic              count_load,
    output logic [2:0]        mode,
    output logic              bcd
);
    localparam logic [1:0] ID = COUNTER_ID[1:0];

    rw_e         rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic        wr_msb_q, wr_msb_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] count_value_q, count_value_d;
    logic        count_load_q, load_d;
    logic        null_count_q, null_count_d;

    logic        wr_acc, rd_acc, ctrl_wr, data_wr;
    logic        prog, latch_cmd, rb_hit;
    logic [1:0]  sc;
    rw_e         rw_f;

    // a simultaneous read is dropped in favour of the write
    assign wr_acc    = bus.cs && bus.wr;
    assign rd_acc    = bus.cs && bus.rd && !bus.wr;
    assign ctrl_wr   = wr_acc && (bus.addr == CTRL_ADDR);
    assign data_wr   = wr_acc && (bus.addr == ID);
    assign sc        = bus.data_in[SC_HI:SC_LO];
    assign rw_f      = rw_e'(bus.data_in[RW_HI:RW_LO]);
    assign prog      = ctrl_wr && (sc == ID) && (rw_f != RW_LATCH);
    assign latch_cmd = ctrl_wr && (sc == ID) && (rw_f == RW_LATCH);
    assign rb_hit    = ctrl_wr && (sc == READBACK_SC) && bus.data_in[RB_SEL_LO + COUNTER_ID];

    always_comb begin
        rw_d          = rw_q;
        mode_d        = mode_q;
        bcd_d         = bcd_q;
        wr_msb_d      = wr_msb_q;
        lsb_d         = lsb_q;
        count_value_d = count_value_q;
        load_d        = 1'b0;

        if (prog) begin
            rw_d     = rw_f;
            mode_d   = map_mode(bus.data_in[M_HI:M_LO]);
            bcd_d    = bus.data_in[BCD_BIT];
            wr_msb_d = 1'b0;
            lsb_d    = '0;
        end else if (data_wr) begin
            case (rw_q)
                RW_LSB: begin
                    count_value_d = {8'h00, bus.data_in};
                    load_d        = 1'b1;
                end
                RW_MSB: begin
                    count_value_d = {bus.data_in, 8'h00};
                    load_d        = 1'b1;
                end
                RW_LSB_MSB: begin
                    if (!wr_msb_q) begin
                        lsb_d    = bus.data_in;
                        wr_msb_d = 1'b1;
                    end else begin
                        count_value_d = {bus.data_in, lsb_q};
                        wr_msb_d      = 1'b0;
                        load_d        = 1'b1;
                    end
                end
                default: ;  // unprogrammed channel ignores data writes
            endcase
        end

        // set beats clear when both land in the same cycle
        if (prog || load_d)
            null_count_d = 1'b1;
        else if (ce_loaded)
            null_count_d = 1'b0;
        else
            null_count_d = null_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q          <= RW_LATCH;
            mode_q        <= '0;
            bcd_q         <= 1'b0;
            wr_msb_q      <= 1'b0;
            lsb_q         <= '0;
            count_value_q <= '0;
            count_load_q  <= 1'b0;
            null_count_q  <= 1'b1;
        end else begin
            rw_q          <= rw_d;
            mode_q        <= mode_d;
            bcd_q         <= bcd_d;
            wr_msb_q      <= wr_msb_d;
            lsb_q         <= lsb_d;
            count_value_q <= count_value_d;
            count_load_q  <= load_d;
            null_count_q  <= null_count_d;
        end
    end

    count_latch u_count_latch (
        .clk           (clk),
        .rst           (rst),
        .clear         (prog),
        .latch_count   (latch_cmd || (rb_hit && !bus.data_in[RB_NCOUNT_BIT])),
        .latch_status  (rb_hit && !bus.data_in[RB_NSTATUS_BIT]),
        .status_in     (make_status(out_pin, null_count_q, rw_q, mode_q, bcd_q)),
        .current_count (current_count),
        .rw            (rw_q),
        .rd_en         (rd_acc && (bus.addr == ID)),
        .data_out      (bus.data_out)
    );

    assign count_value = count_value_q;
    assign count_load  = count_load_q;
    assign mode        = mode_q;
    assign bcd         = bcd_q;
endmodule
